// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC datapath.
//   FLOAT_DATA_WIDTH  : width of the IEEE-754 single output word
//   INTEGER_WIDTH     : integer bits of the fixed-point operand (sign included)
//   FRACTIONAL_WIDTH  : fractional bits of the fixed-point operand
//   CORDIC_DATA_WIDTH : total fixed-point operand width
//   EXP_BIAS          : IEEE single-precision exponent bias
//   f2f_state_t       : state encoding of the fixed_to_float FSM
package cordic_pkg;

  localparam int FLOAT_DATA_WIDTH  = 32;
  localparam int INTEGER_WIDTH     = 4;
  localparam int FRACTIONAL_WIDTH  = 20;
  localparam int CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH;
  localparam int EXP_BIAS          = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ABS  = 2'd1,
    ST_NORM = 2'd2,
    ST_PACK = 2'd3
  } f2f_state_t;

endpackage

// File: rtl/fixed_to_float.sv
// fixed_to_float: converts the signed Q4.20 CORDIC result into an IEEE-754
// single-precision word, normalising one bit per cycle.
//
// state | meaning
// IDLE  | waiting for clk_en; result holds the last conversion
// ABS   | take sign and magnitude, preset exponent, detect zero
// NORM  | shift magnitude left until its MSB is set
// PACK  | assemble the float word, pulse done
//
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset, priority over clk_en
//   clk_en   : start pulse, only honoured in IDLE
//   fixed_in : signed Q4.20 operand, captured with clk_en
//   negate   : flip output sign, captured with clk_en
//   result   : IEEE-754 single, held until the next completion
//   done     : one-cycle pulse when result updates
//   busy     : high in every state except IDLE
module fixed_to_float
  import cordic_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic [CORDIC_DATA_WIDTH-1:0] fixed_in,
  input  logic                         negate,
  output logic [FLOAT_DATA_WIDTH-1:0]  result,
  output logic                         done,
  output logic                         busy
);

  localparam int MSB = CORDIC_DATA_WIDTH - 1;
  // Exponent of a value whose leading one sits at the operand MSB.
  localparam logic [7:0] EXP_INIT = 8'(EXP_BIAS + INTEGER_WIDTH - 1);

  f2f_state_t                   state;
  logic [CORDIC_DATA_WIDTH-1:0] fixed_q;
  logic                         negate_q;
  logic [CORDIC_DATA_WIDTH-1:0] mag;
  logic [7:0]                   exp_q;
  logic                         sign_q;
  logic                         zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fixed_q  <= '0;
      negate_q <= 1'b0;
      mag      <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clk_en) begin
            fixed_q  <= fixed_in;
            negate_q <= negate;
            state    <= ST_ABS;
          end
        end
        ST_ABS: begin
          sign_q <= fixed_q[MSB] ^ negate_q;
          // Two's complement of the most negative value wraps to itself,
          // which is exactly its unsigned magnitude.
          mag    <= fixed_q[MSB] ? (~fixed_q + 24'd1) : fixed_q;
          exp_q  <= EXP_INIT;
          zero_q <= (fixed_q == '0);
          state  <= (fixed_q == '0) ? ST_PACK : ST_NORM;
        end
        ST_NORM: begin
          if (mag[MSB]) begin
            state <= ST_PACK;
          end else begin
            mag   <= mag << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        ST_PACK: begin
          // Zero is always packed as +0.
          result <= zero_q ? '0 : {sign_q, exp_q, mag[MSB-1:0]};
          done   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fixed_to_float.sv
module tb_fixed_to_float;
  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic [23:0] fixed_in = '0;
  logic        negate = 1'b0;
  logic [31:0] result;
  logic        done;
  logic        busy;

  fixed_to_float dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .fixed_in (fixed_in),
    .negate   (negate),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending
  // conversion, both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check32("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check32("result", result, e.res);
        check32("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive a start at the current (negedge) time; sampling edge is cyc+1.
  task automatic issue(input logic [23:0] f, input logic n, input logic [31:0] r,
                       input int lat, input bit push);
    clk_en   = 1'b1;
    fixed_in = f;
    negate   = n;
    if (push) sb.push_back('{r, cyc + 1 + lat});
  endtask

  task automatic start(input logic [23:0] f, input logic n, input logic [31:0] r,
                       input int lat);
    @(negedge clk);
    issue(f, n, r, lat, 1'b1);
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check32("drain_pending", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check32("reset_result", result, 32'h0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // 1.0, with busy profile around completion
    start(24'h100000, 1'b0, 32'h3F800000, 6);
    repeat (5) @(negedge clk);
    check32("busy_in_pack", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check32("busy_after_done", {31'd0, busy}, 32'd0);
    wait_idle();

    start(24'h800000, 1'b0, 32'hC1000000, 3);
    wait_idle();
    start(24'h800000, 1'b1, 32'h41000000, 3);
    wait_idle();
    start(24'h000001, 1'b0, 32'h35800000, 26);
    wait_idle();
    start(24'h7FFFFF, 1'b0, 32'h40FFFFFE, 4);
    wait_idle();
    start(24'h000000, 1'b1, 32'h00000000, 2);
    wait_idle();
    start(24'h080000, 1'b1, 32'hBF000000, 7);
    wait_idle();
    start(24'hF00000, 1'b0, 32'hBF800000, 6);
    wait_idle();

    // clk_en during NORM is ignored
    start(24'h000001, 1'b1, 32'hB5800000, 26);
    repeat (5) @(negedge clk);
    issue(24'h100000, 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    clk_en = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check32("idle_after_ignored", {31'd0, busy}, 32'd0);

    // clk_en on the done cycle starts the next conversion
    start(24'h100000, 1'b0, 32'h3F800000, 6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    issue(24'h7FFFFF, 1'b0, 32'h40FFFFFE, 4, 1'b1);
    @(negedge clk);
    clk_en = 1'b0;
    wait_idle();

    // reset in NORM aborts with no done
    @(negedge clk);
    issue(24'h000001, 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_result", result, 32'h0);
    check32("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check32("abort_result_held", result, 32'h0);
    start(24'h100000, 1'b0, 32'h3F800000, 6);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
